// File: rtl/key_cfg_ctrl.sv
// Four-key NCO frequency-word command controller: pending requests, fixed-priority grant,
// saturating step arithmetic and a valid/ready config handshake. Optional auto-repeat: KEY_REPEAT_EN.
module key_cfg_ctrl #(
  parameter int unsigned           FW_WIDTH   = 32,
  parameter logic [FW_WIDTH-1:0]   FW_DEFAULT = 32'd85_899_346,
  parameter logic [FW_WIDTH-1:0]   FW_MIN     = 32'd0,
  parameter logic [FW_WIDTH-1:0]   FW_MAX     = 32'hFFFF_FFFF,
  parameter logic [FW_WIDTH-1:0]   STEP_BASE  = 32'd42_950,
  // 26 bits so the 0.5 s default hold time at 100 MHz is representable
  parameter logic [25:0]           REPEAT_DLY = 26'd49_999_999,
  parameter logic [25:0]           REPEAT_PER = 26'd9_999_999
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [3:0]          key_flag,
  input  logic [3:0]          key_in,
  input  logic                cfg_ready,
  output logic [FW_WIDTH-1:0] freq_word,
  output logic                cfg_valid,
  output logic [1:0]          step_idx,
  output logic                busy,
  output logic                sat_flag
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] APPLY = 2'd2;

  logic [1:0]          state;
  logic [3:0]          pend;
  logic [3:0]          cmd;
  logic [3:0]          grant;
  logic [3:0]          rep_set;
  logic [FW_WIDTH-1:0] step;
  logic [FW_WIDTH:0]   sum;
  logic [FW_WIDTH:0]   diff;
  logic                inc_sat;
  logic                dec_sat;

  // Priority key3 > key0 > key1 > key2
  always_comb begin
    grant = '0;
    if (state == IDLE) begin
      if (pend[3])      grant = 4'b1000;
      else if (pend[0]) grant = 4'b0001;
      else if (pend[1]) grant = 4'b0010;
      else if (pend[2]) grant = 4'b0100;
    end
  end

  assign step    = STEP_BASE << {step_idx, 1'b0};
  assign sum     = {1'b0, freq_word} + {1'b0, step};
  assign diff    = {1'b0, freq_word} - {1'b0, step};
  assign inc_sat = sum > {1'b0, FW_MAX};
  assign dec_sat = $signed(diff) < $signed({1'b0, FW_MIN});

  assign sat_flag = (state == CALC) && ((cmd[0] && inc_sat) || (cmd[1] && dec_sat));
  // Pending requests count as busy so the gap before the grant is covered
  assign busy     = (state != IDLE) || (|pend);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      pend      <= '0;
      cmd       <= '0;
      freq_word <= FW_DEFAULT;
      step_idx  <= '0;
      cfg_valid <= 1'b0;
    end else begin
      pend <= (pend & ~grant) | key_flag | rep_set;
      case (state)
        IDLE: begin
          if (|pend) begin
            cmd   <= grant;
            state <= CALC;
          end
        end
        CALC: begin
          if (cmd[0]) freq_word <= inc_sat ? FW_MAX : sum[FW_WIDTH-1:0];
          if (cmd[1]) freq_word <= dec_sat ? FW_MIN : diff[FW_WIDTH-1:0];
          if (cmd[2]) step_idx  <= step_idx + 2'd1;
          if (cmd[3]) begin
            freq_word <= FW_DEFAULT;
            step_idx  <= '0;
          end
          cfg_valid <= 1'b1;
          state     <= APPLY;
        end
        APPLY: begin
          if (cfg_ready) begin
            cfg_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_REPEAT_EN
  localparam logic [26:0] REP_FIRST = {1'b0, REPEAT_DLY};
  localparam logic [26:0] REP_TOP   = {1'b0, REPEAT_DLY} + {1'b0, REPEAT_PER};

  logic unused_keys;
  assign unused_keys = &{1'b0, key_in[3:2]};
  assign rep_set[3:2] = '0;

  for (genvar g = 0; g < 2; g++) begin : g_rep
    logic [26:0] hold_cnt;
    // After the first hit the counter is parked just past REP_FIRST so REP_TOP recurs every REPEAT_PER
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)               hold_cnt <= '0;
      else if (key_in[g])           hold_cnt <= '0;
      else if (hold_cnt == REP_TOP) hold_cnt <= REP_FIRST + 27'd1;
      else                          hold_cnt <= hold_cnt + 27'd1;
    end
    assign rep_set[g] = !key_in[g] && ((hold_cnt == REP_FIRST) || (hold_cnt == REP_TOP));
  end
`else
  logic unused_rep;
  assign unused_rep = &{1'b0, key_in, REPEAT_DLY, REPEAT_PER};
  assign rep_set    = '0;
`endif

endmodule

// File: tb/tb_key_cfg_ctrl.sv
// Directed self-checking bench for key_cfg_ctrl; a second instance with a low FW_MAX covers clamping.
module tb_key_cfg_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [3:0]  key_flag = '0, key_flag_s = '0;
  logic [3:0]  key_in = 4'hF, key_in_s = 4'hF;
  logic        cfg_ready = 1'b1, cfg_ready_s = 1'b1;
  logic [31:0] freq_word, fw_s;
  logic [1:0]  step_idx, step_s;
  logic        cfg_valid, busy, sat_flag, valid_s, busy_s, sat_s;

  int n_cmp = 0;
  int n_bad = 0;
  int hs = 0;
  int sat_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  key_cfg_ctrl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key_flag), .key_in(key_in),
    .cfg_ready(cfg_ready), .freq_word(freq_word), .cfg_valid(cfg_valid),
    .step_idx(step_idx), .busy(busy), .sat_flag(sat_flag)
  );

  key_cfg_ctrl #(.FW_MAX(32'd85_900_000)) dut_sat (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key_flag_s), .key_in(key_in_s),
    .cfg_ready(cfg_ready_s), .freq_word(fw_s), .cfg_valid(valid_s),
    .step_idx(step_s), .busy(busy_s), .sat_flag(sat_s)
  );

`ifdef KEY_REPEAT_EN
  logic [3:0]  key_in_r = 4'hF;
  logic [3:0]  key_flag_r = '0;
  logic [31:0] fw_r;
  logic [1:0]  step_r;
  logic        valid_r, busy_r, sat_r;

  key_cfg_ctrl #(.REPEAT_DLY(26'd20), .REPEAT_PER(26'd10)) dut_rep (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key_flag_r), .key_in(key_in_r),
    .cfg_ready(cfg_ready), .freq_word(fw_r), .cfg_valid(valid_r),
    .step_idx(step_r), .busy(busy_r), .sat_flag(sat_r)
  );
`endif

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    key_flag = '0;
    key_flag_s = '0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  // Runs until the selected instance is idle, tallying handshakes and clamp pulses
  task automatic drain(input bit which, input int limit);
    int i = 0;
    while (i < limit && (which ? (busy_s || valid_s) : (busy || cfg_valid))) begin
      if (which ? (valid_s && cfg_ready_s) : (cfg_valid && cfg_ready)) hs++;
      if (which ? sat_s : sat_flag) sat_cnt++;
      tick();
      i++;
    end
    n_cmp++;
    if (which ? (busy_s || valid_s) : (busy || cfg_valid)) begin
      n_bad++;
      $display("FAIL drain_timeout dut%0d: still busy after %0d cycles, expected idle", which, limit);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (freq_word !== 32'd85_899_346) begin n_bad++; $display("FAIL rst_freq got=%0d exp=85899346", freq_word); end
    n_cmp++; if (step_idx !== 2'd0) begin n_bad++; $display("FAIL rst_step got=%0d exp=0", step_idx); end
    n_cmp++; if (cfg_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", cfg_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (sat_flag !== 1'b0) begin n_bad++; $display("FAIL rst_sat got=%b exp=0", sat_flag); end
    n_cmp++; if (fw_s !== 32'd85_899_346) begin n_bad++; $display("FAIL rst_freq_s got=%0d exp=85899346", fw_s); end
  endtask

  task automatic test_latency();
    logic [4:0] v_exp = 5'b01000;
    logic [4:0] b_exp = 5'b01110;
    cfg_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      key_flag = (c == 0) ? 4'b0001 : 4'b0000;
      n_cmp++; if (cfg_valid !== v_exp[c]) begin n_bad++; $display("FAIL lat_valid c%0d got=%b exp=%b", c, cfg_valid, v_exp[c]); end
      n_cmp++; if (busy !== b_exp[c]) begin n_bad++; $display("FAIL lat_busy c%0d got=%b exp=%b", c, busy, b_exp[c]); end
      if (c == 3) begin
        n_cmp++; if (freq_word !== 32'd85_942_296) begin n_bad++; $display("FAIL lat_freq got=%0d exp=85942296", freq_word); end
      end
      tick();
    end
    n_cmp++; if (freq_word !== 32'd85_942_296) begin n_bad++; $display("FAIL lat_freq_hold got=%0d exp=85942296", freq_word); end
  endtask

  // Second key2 lands in its own grant cycle and must still be served
  task automatic test_step_cycle();
    do_reset();
    cfg_ready = 1'b1;
    hs = 0;
    key_flag = 4'b0100; tick();
    key_flag = 4'b0100; tick();
    key_flag = 4'b0000;
    drain(0, 50);
    n_cmp++; if (step_idx !== 2'd2) begin n_bad++; $display("FAIL step_idx got=%0d exp=2", step_idx); end
    key_flag = 4'b0001; tick();
    key_flag = 4'b0000;
    drain(0, 50);
    n_cmp++; if (freq_word !== 32'd86_586_546) begin n_bad++; $display("FAIL step_freq got=%0d exp=86586546", freq_word); end
    n_cmp++; if (hs !== 3) begin n_bad++; $display("FAIL step_hs got=%0d exp=3", hs); end
  endtask

  task automatic test_saturation();
    logic [4:0] s_exp = 5'b00100;
    cfg_ready_s = 1'b1;
    for (int c = 0; c < 5; c++) begin
      key_flag_s = (c == 0) ? 4'b0001 : 4'b0000;
      n_cmp++; if (sat_s !== s_exp[c]) begin n_bad++; $display("FAIL sat_pulse c%0d got=%b exp=%b", c, sat_s, s_exp[c]); end
      tick();
    end
    drain(1, 50);
    n_cmp++; if (fw_s !== 32'd85_900_000) begin n_bad++; $display("FAIL sat_clamp got=%0d exp=85900000", fw_s); end
    sat_cnt = 0;
    key_flag_s = 4'b0010; tick();
    key_flag_s = 4'b0000;
    drain(1, 50);
    n_cmp++; if (sat_cnt !== 0) begin n_bad++; $display("FAIL sat_dec_pulses got=%0d exp=0", sat_cnt); end
    n_cmp++; if (fw_s !== 32'd85_857_050) begin n_bad++; $display("FAIL sat_dec got=%0d exp=85857050", fw_s); end
  endtask

  task automatic test_priority();
    cfg_ready = 1'b0;
    hs = 0;
    for (int c = 0; c < 10; c++) begin
      key_flag = (c == 0) ? 4'b1001 : 4'b0000;
      if (c >= 3) begin
        n_cmp++; if (cfg_valid !== 1'b1) begin n_bad++; $display("FAIL prio_valid c%0d got=%b exp=1", c, cfg_valid); end
        n_cmp++; if (freq_word !== 32'd85_899_346) begin n_bad++; $display("FAIL prio_hold c%0d got=%0d exp=85899346", c, freq_word); end
        n_cmp++; if (step_idx !== 2'd0) begin n_bad++; $display("FAIL prio_step c%0d got=%0d exp=0", c, step_idx); end
      end
      tick();
    end
    cfg_ready = 1'b1;
    drain(0, 50);
    n_cmp++; if (freq_word !== 32'd85_942_296) begin n_bad++; $display("FAIL prio_second got=%0d exp=85942296", freq_word); end
    n_cmp++; if (hs !== 2) begin n_bad++; $display("FAIL prio_hs got=%0d exp=2", hs); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    cfg_ready = 1'b0;
    key_flag = 4'b0001; tick();
    key_flag = 4'b0000; tick();
    tick();
    n_cmp++; if (cfg_valid !== 1'b1) begin n_bad++; $display("FAIL abort_apply got=%b exp=1", cfg_valid); end
    #2 sys_rst_n = 1'b0;
    #1;
    n_cmp++; if (freq_word !== 32'd85_899_346) begin n_bad++; $display("FAIL abort_freq got=%0d exp=85899346", freq_word); end
    n_cmp++; if (cfg_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid got=%b exp=0", cfg_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    tick();
    sys_rst_n = 1'b1;
    cfg_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++; if (cfg_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL abort_quiet c%0d valid=%b busy=%b exp=0/0", c, cfg_valid, busy); end
    end
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat();
    int rep_hs = 0;
    do_reset();
    cfg_ready = 1'b1;
    key_in_r = 4'b1110;
    for (int c = 0; c < 45; c++) begin
      if (valid_r) rep_hs++;
      tick();
    end
    key_in_r = 4'hF;
    for (int c = 0; c < 20; c++) begin
      if (valid_r) rep_hs++;
      tick();
    end
    n_cmp++; if (rep_hs !== 3) begin n_bad++; $display("FAIL rep_count got=%0d exp=3", rep_hs); end
    n_cmp++; if (fw_r !== 32'd86_028_196) begin n_bad++; $display("FAIL rep_freq got=%0d exp=86028196", fw_r); end
  endtask
`endif

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_step_cycle();
    test_saturation();
    test_priority();
    test_reset_abort();
`ifdef KEY_REPEAT_EN
    test_repeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
